// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for a 5-stage MIPS-style core.
// Detects load-use hazards, squashes the fetch slot after jumps and taken
// branches, and optionally stalls the front end for a multi-cycle multiply.
// Optional feature macro: HAZARD_MULT_STALL_EN (multiply stall state + counter).
// Without the macro, ID_Mult is ignored and MULT_BUSY can never be entered.
module hazard_unit #(
  parameter int MULT_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  ID_RegRs,
  input  logic [4:0]  ID_RegRt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_Jump,
  input  logic        ID_Mult,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegDst,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IFID_JFlush,
  output logic        IDEX_Flush,
  output logic [1:0]  HazState,
  output logic [15:0] StallCycles
);

  // State encoding is visible on HazState, so the values are fixed.
  localparam logic [1:0] RUN       = 2'b00;
  localparam logic [1:0] BR_WAIT   = 2'b01;
  localparam logic [1:0] J_FLUSH   = 2'b10;
  localparam logic [1:0] MULT_BUSY = 2'b11;

  // Counter reload value; MULT_CYCLES is legal only in 2..15 so it fits 4 bits.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic        w_loadUse;
  logic        w_multReq;
  logic        w_runPcWrite;
  logic        w_runIfidWrite;
  logic        w_runIdexFlush;
  logic [1:0]  w_runNext;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  // Register 0 is hardwired to zero, so it never creates a dependency.
  always_comb begin
    w_loadUse = EX_MemRead && (EX_RegDst != 5'd0) &&
                ((EX_RegDst == ID_RegRs) ||
                 (ID_UsesRt && (EX_RegDst == ID_RegRt)));
  end

`ifdef HAZARD_MULT_STALL_EN
  logic [3:0] r_multCnt;

  // Multiply requests only matter when the stall feature is built in.
  always_comb begin
    w_multReq = ID_Mult;
  end
`else
  logic [4:0] w_unusedMultCfg;

  // Without the feature ID_Mult is dropped; keep it tied off visibly.
  always_comb begin
    w_multReq       = 1'b0;
    w_unusedMultCfg = {ID_Mult, MULT_LOAD};
  end
`endif

  // Normal-flow decision shared by RUN and a not-taken BR_WAIT: a load-use
  // stall wins over every ID decode, then jump, branch, multiply in order.
  always_comb begin
    w_runPcWrite   = 1'b1;
    w_runIfidWrite = 1'b1;
    w_runIdexFlush = 1'b0;
    w_runNext      = RUN;
    if (w_loadUse) begin
      w_runPcWrite   = 1'b0;
      w_runIfidWrite = 1'b0;
      w_runIdexFlush = 1'b1;
      w_runNext      = RUN;
    end else if (ID_Jump) begin
      w_runNext = J_FLUSH;
    end else if (ID_Branch) begin
      w_runNext = BR_WAIT;
    end else if (w_multReq) begin
      w_runNext = MULT_BUSY;
    end
  end

  // Output and next-state decode; reset forces a frozen, flushed pipeline.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IFID_JFlush = 1'b0;
    IDEX_Flush  = 1'b0;
    w_nextState = RUN;
    if (!Reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      IFID_JFlush = 1'b0;
      w_nextState = RUN;
    end else begin
      case (r_state)
        RUN: begin
          PCWrite     = w_runPcWrite;
          IFID_Write  = w_runIfidWrite;
          IDEX_Flush  = w_runIdexFlush;
          w_nextState = w_runNext;
        end
        BR_WAIT: begin
          if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            w_nextState = RUN;
          end else begin
            PCWrite     = w_runPcWrite;
            IFID_Write  = w_runIfidWrite;
            IDEX_Flush  = w_runIdexFlush;
            w_nextState = w_runNext;
          end
        end
        J_FLUSH: begin
          IFID_Flush  = 1'b1;
          IFID_JFlush = 1'b1;
          w_nextState = RUN;
        end
`ifdef HAZARD_MULT_STALL_EN
        MULT_BUSY: begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
          if (r_multCnt == 4'd0) begin
            w_nextState = RUN;
          end else begin
            w_nextState = MULT_BUSY;
          end
        end
`endif
        default: begin
          w_nextState = RUN;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

`ifdef HAZARD_MULT_STALL_EN
  // Multiply countdown: loaded on entry, counts down while busy.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_multCnt <= 4'd0;
    end else if ((r_state != MULT_BUSY) && (w_nextState == MULT_BUSY)) begin
      r_multCnt <= MULT_LOAD;
    end else if ((r_state == MULT_BUSY) && (r_multCnt != 4'd0)) begin
      r_multCnt <= r_multCnt - 4'd1;
    end
  end
`endif

  // Saturating stall counter; reset cycles are not counted.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      StallCycles <= 16'd0;
    end else if (!PCWrite && (StallCycles != 16'hFFFF)) begin
      StallCycles <= StallCycles + 16'd1;
    end
  end

  assign HazState = r_state;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 4, legal range 2..15: stall length for a multiply in ID.
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  reset is synchronous and active-low.
REQ-004 ID_RegRs  in  5  rs field of the instruction in ID.
REQ-005 ID_RegRt  in  5  rt field of the instruction in ID.
REQ-006 ID_UsesRt  in  1  instruction in ID reads rt.
REQ-007 ID_Branch  in  1  Branch decode of the instruction in ID.
REQ-008 ID_Jump  in  1  Jump decode of the instruction in ID (J, JAL, JR).
REQ-009 ID_Mult  in  1  instruction in ID has opcode 011100.
REQ-010 EX_MemRead  in  1  instruction in EX is a load.
REQ-011 EX_RegDst  in  5  destination register of the instruction in EX.
REQ-012 BranchTaken  in  1  branch outcome; valid only in state BR_WAIT.
REQ-013 PCWrite  out  1  PC update enable.
REQ-014 IFID_Write  out  1  IF/ID register write enable.
REQ-015 IFID_Flush  out  1  zero the IF/ID register on the next edge.
REQ-016 IFID_JFlush  out  1  jump squash indication, fed to the datapath controller.
REQ-017 IDEX_Flush  out  1  insert a bubble (all control zero) into ID/EX.
REQ-018 HazState  out  2  current state: RUN=00, BR_WAIT=01, J_FLUSH=10, MULT_BUSY=11.
REQ-019 StallCycles  out  16  count of cycles with PCWrite=0.

Function
REQ-020 LoadUse shall be EX_MemRead & (EX_RegDst!=0) & (EX_RegDst==ID_RegRs | (ID_UsesRt & EX_RegDst==ID_RegRt)).
REQ-021 Outputs are combinational from state, LoadUse and BranchTaken; defaults PCWrite=1, IFID_Write=1, others 0.
REQ-022 Stall pattern: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
REQ-023 RUN with LoadUse: stall pattern; remain RUN; ID_Branch, ID_Jump and ID_Mult are ignored that cycle.
REQ-024 RUN without LoadUse: priority ID_Jump -> J_FLUSH; else ID_Branch -> BR_WAIT; else ID_Mult -> MULT_BUSY (if enabled); else stay RUN.
REQ-025 J_FLUSH: IFID_Flush=1, IFID_JFlush=1 for exactly one cycle; next state RUN unconditionally.
REQ-026 BR_WAIT with BranchTaken=1: IFID_Flush=1; next state RUN; ID-stage decode inputs ignored.
REQ-027 BR_WAIT with BranchTaken=0: the state applies the RUN rules (REQ-023/024) to the instruction in ID; back-to-back branches re-enter BR_WAIT.
REQ-028 MULT_BUSY entry loads a 4-bit counter with MULT_CYCLES-1.
REQ-029 MULT_BUSY asserts the stall pattern every cycle, decrements the counter, and returns to RUN in the cycle after the counter reads 0; total stall = MULT_CYCLES cycles.
REQ-030 MULT_BUSY: LoadUse, ID_Branch and ID_Jump have no effect.
REQ-031 StallCycles shall increment on every edge where PCWrite=0, saturate at 16'hFFFF, and never wrap.

Reset
REQ-032 While Reset=0 at an edge: state=RUN, multiply counter=0, StallCycles=0.
REQ-033 While Reset=0 (combinational): PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, IFID_JFlush=0; StallCycles does not count.
REQ-034 Reset asserted in any state, including mid-MULT_BUSY or BR_WAIT, aborts that state; the first cycle after release is RUN.

Configuration
REQ-035 Macro HAZARD_MULT_STALL_EN defined: ID_Mult, MULT_BUSY and the counter behave per REQ-028..030.
REQ-036 Macro HAZARD_MULT_STALL_EN undefined: ID_Mult is ignored; MULT_BUSY is unreachable; the counter is not built; HazState never reads 11.

Verification
REQ-037 EX_MemRead=1, EX_RegDst=5, ID_RegRs=5 -> one cycle PCWrite=0, IDEX_Flush=1; with EX_RegDst=0 -> no stall.
REQ-038 ID_Jump=1 in RUN -> next cycle HazState=10, IFID_JFlush=1, IFID_Flush=1; following cycle RUN, flushes 0.
REQ-039 ID_Branch=1, then BranchTaken=1 -> IFID_Flush=1 in BR_WAIT; BranchTaken=0 with ID_Branch=1 -> stays BR_WAIT.
REQ-040 With macro defined, MULT_CYCLES=4: ID_Mult=1 -> exactly 4 stall cycles, then RUN; StallCycles advances by 4.
REQ-041 Reset=0 during the 2nd MULT_BUSY cycle -> next cycle RUN, StallCycles=0; StallCycles preloaded to FFFF by forcing stalls -> stays FFFF.
